// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB completer with fixed wait states, error decode, ID/status/control register file
module apb_reg_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] hw_status,
  output logic [DATA_WIDTH-1:0] ctrl_out
);
  localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((1 << ADDR_LSB) - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] regs_q [2:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [2:NUM_REGS-1];

  logic                  setup, sel_write, bad, commit;
  logic [ADDR_WIDTH-1:0] sel_addr, word;
  logic [IDX_W-1:0]      ridx, widx;
  logic [DATA_WIDTH-1:0] rdata;

  // Decode the access that is about to be answered: a fresh setup uses the live bus, otherwise the latched one
  always_comb begin
    setup     = pselx & ~penable;
    sel_addr  = setup ? paddr : addr_q;
    sel_write = setup ? pwrite : write_q;
    word      = sel_addr >> ADDR_LSB;
    ridx      = word[IDX_W-1:0];
    widx      = addr_q[ADDR_LSB +: IDX_W];
    bad       = (|(sel_addr & LSB_MASK)) | (word >= ADDR_WIDTH'(NUM_REGS)) |
                (sel_write & (word < ADDR_WIDTH'(2)));
    commit    = (state_q == RESP) & pselx & penable & write_q & ~pslverr_q;
  end

  // Read mux; reg 1 is the live status word so it is sampled on the edge that loads prdata
  always_comb begin
    rdata = (ridx == IDX_W'(0)) ? ID_VALUE : (ridx == IDX_W'(1)) ? hw_status : '0;
    for (int i = 2; i < NUM_REGS; i++)
      if (ridx == IDX_W'(i)) rdata = regs_q[i];
  end

  // RW registers only change on the completing RESP edge of a clean, still-selected write
  always_comb begin
    for (int i = 2; i < NUM_REGS; i++)
      regs_d[i] = (commit && widx == IDX_W'(i)) ? wdata_q : regs_q[i];
  end

  // Transfer FSM: any setup phase restarts the transfer, a dropped select falls back to IDLE
  always_comb begin
    state_d = IDLE;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    if (setup) begin
      addr_d  = paddr;
      write_d = pwrite;
      wdata_d = pwdata;
      cnt_d   = 4'(WAIT_STATES);
      state_d = (WAIT_STATES == 0) ? RESP : WAIT;
    end else if (state_q == WAIT && pselx) begin
      state_d = (cnt_q == 4'd1) ? RESP : WAIT;
      cnt_d   = cnt_q - 4'd1;
    end
  end

  // Response outputs are loaded on the edge entering RESP and cleared on the edge leaving it
  always_comb begin
    pready_d  = state_d == RESP;
    pslverr_d = pready_d & bad;
    prdata_d  = (pready_d & ~bad & ~sel_write) ? rdata : '0;
  end

  // State and register flops, cleared asynchronously
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      for (int i = 2; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      regs_q    <= regs_d;
    end
  end

  assign prdata   = prdata_q;
  assign pready   = pready_q;
  assign pslverr  = pslverr_q;
  assign ctrl_out = regs_q[2];
endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: directed checks of apb_reg_slave at WAIT_STATES = 0, 1 and 3
module tb_apb_reg_slave;
  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata, hw_status;
  logic [31:0] prdata [3];
  logic [31:0] ctrl_out [3];
  logic        pready [3];
  logic        pslverr [3];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] rd;
  logic        err;
  int          waits;

  always #5 pclk = ~pclk;

  apb_reg_slave #(.WAIT_STATES(0)) u_ws0 (
    .pclk(pclk), .presetn(presetn), .pselx(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0]), .hw_status(hw_status), .ctrl_out(ctrl_out[0]));
  apb_reg_slave #(.WAIT_STATES(1)) u_ws1 (
    .pclk(pclk), .presetn(presetn), .pselx(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1]), .hw_status(hw_status), .ctrl_out(ctrl_out[1]));
  apb_reg_slave #(.WAIT_STATES(3)) u_ws3 (
    .pclk(pclk), .presetn(presetn), .pselx(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[2]), .pready(pready[2]),
    .pslverr(pslverr[2]), .hw_status(hw_status), .ctrl_out(ctrl_out[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full transfer on instance d, entered and left on a falling edge; counts access cycles with pready=0
  task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] r, output logic e, output int w);
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    @(negedge pclk);
    penable = 1'b1;
    w = 0;
    while (!pready[d] && w < 32) begin
      w++;
      @(negedge pclk);
    end
    chk("pready_seen", {31'd0, pready[d]}, 32'd1);
    r = prdata[d];
    e = pslverr[d];
    @(negedge pclk);
    psel    = '0;
    penable = 1'b0;
  endtask

  initial begin
    presetn = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; hw_status = '0;
    repeat (2) @(negedge pclk);
    chk("rst_pready", {31'd0, pready[1]}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr[1]}, 32'd0);
    chk("rst_prdata", prdata[1], 32'd0);
    chk("rst_ctrl", ctrl_out[1], 32'd0);
    presetn = 1'b1;
    @(negedge pclk);

    xfer(1, 1'b1, 32'h8, 32'h1234_5678, rd, err, waits);
    chk("wr8_waits", 32'(waits), 32'd1);
    chk("wr8_err", {31'd0, err}, 32'd0);
    chk("wr8_ctrl", ctrl_out[1], 32'h1234_5678);
    chk("wr8_idle", {31'd0, pready[1]}, 32'd0);

    xfer(1, 1'b0, 32'h0, 32'h0, rd, err, waits);
    chk("rd_id", rd, ID);
    chk("rd_id_err", {31'd0, err}, 32'd0);
    hw_status = 32'hDEAD_BEEF;
    xfer(1, 1'b0, 32'h4, 32'h0, rd, err, waits);
    chk("rd_status", rd, 32'hDEAD_BEEF);

    xfer(1, 1'b1, 32'h0, 32'hFFFF_FFFF, rd, err, waits);
    chk("wr0_err", {31'd0, err}, 32'd1);
    xfer(1, 1'b1, 32'h4, 32'hFFFF_FFFF, rd, err, waits);
    chk("wr4_err", {31'd0, err}, 32'd1);
    xfer(1, 1'b0, 32'h20, 32'h0, rd, err, waits);
    chk("rd20_err", {31'd0, err}, 32'd1);
    chk("rd20_data", rd, 32'd0);
    xfer(1, 1'b0, 32'h9, 32'h0, rd, err, waits);
    chk("rd9_err", {31'd0, err}, 32'd1);
    chk("rd9_data", rd, 32'd0);
    xfer(1, 1'b1, 32'h9, 32'hFFFF_FFFF, rd, err, waits);
    chk("wr9_err", {31'd0, err}, 32'd1);
    chk("wr9_ctrl", ctrl_out[1], 32'h1234_5678);
    xfer(1, 1'b0, 32'h0, 32'h0, rd, err, waits);
    chk("rd_id_again", rd, ID);
    xfer(1, 1'b0, 32'h8, 32'h0, rd, err, waits);
    chk("rd8_keep", rd, 32'h1234_5678);

    xfer(0, 1'b1, 32'hC, 32'hCAFE_F00D, rd, err, waits);
    chk("ws0_wr_waits", 32'(waits), 32'd0);
    chk("ws0_wr_err", {31'd0, err}, 32'd0);
    xfer(0, 1'b0, 32'hC, 32'h0, rd, err, waits);
    chk("ws0_rd_waits", 32'(waits), 32'd0);
    chk("ws0_rdC", rd, 32'hCAFE_F00D);
    xfer(0, 1'b0, 32'h0, 32'h0, rd, err, waits);
    chk("ws0_id", rd, ID);
    xfer(2, 1'b1, 32'hC, 32'h0BAD_F00D, rd, err, waits);
    chk("ws3_wr_waits", 32'(waits), 32'd3);
    xfer(2, 1'b0, 32'hC, 32'h0, rd, err, waits);
    chk("ws3_rd_waits", 32'(waits), 32'd3);
    chk("ws3_rdC", rd, 32'h0BAD_F00D);
    xfer(2, 1'b0, 32'h1C, 32'h0, rd, err, waits);
    chk("ws3_rd1C", rd, 32'd0);
    chk("ws3_rd1C_err", {31'd0, err}, 32'd0);
    xfer(2, 1'b0, 32'h20, 32'h0, rd, err, waits);
    chk("ws3_rd20_err", {31'd0, err}, 32'd1);

    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h55AA_55AA;
    @(negedge pclk);
    chk("abw_wait", {31'd0, pready[1]}, 32'd0);
    psel = '0;
    @(negedge pclk);
    chk("abw_nordy1", {31'd0, pready[1]}, 32'd0);
    @(negedge pclk);
    chk("abw_nordy2", {31'd0, pready[1]}, 32'd0);
    xfer(1, 1'b0, 32'hC, 32'h0, rd, err, waits);
    chk("abw_regC", rd, 32'd0);

    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h7777_7777;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    chk("abr_resp", {31'd0, pready[1]}, 32'd1);
    psel = '0; penable = 1'b0;
    @(negedge pclk);
    chk("abr_idle", {31'd0, pready[1]}, 32'd0);
    chk("abr_ctrl", ctrl_out[1], 32'h1234_5678);

    psel = 3'b010; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    chk("rstx_prdata_pre", prdata[1], ID);
    presetn = 1'b0;
    #1;
    chk("rstx_pready", {31'd0, pready[1]}, 32'd0);
    chk("rstx_prdata", prdata[1], 32'd0);
    chk("rstx_pslverr", {31'd0, pslverr[1]}, 32'd0);
    chk("rstx_ctrl", ctrl_out[1], 32'd0);
    @(negedge pclk);
    presetn = 1'b1; psel = '0; penable = 1'b0;
    @(negedge pclk);
    xfer(1, 1'b0, 32'h8, 32'h0, rd, err, waits);
    chk("rstx_reg8", rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
